// File: rtl/axis64_kvs_rsp_monitor.sv
// axis64_kvs_rsp_monitor
// Response-side monitor for the 64-bit AXI-Stream KVS network path.
// It sinks the to_net response stream and snoops the from_net request
// handshake. It reports request, response and byte counts, plus the
// round-trip latency of each request in to_net clock cycles.
// Requests are timestamped into a small FIFO. Each response end-of-packet
// pops the oldest timestamp and measures the latency against it.
// Optional feature macro: AXIS_MON_BACKPRESSURE_EN. When it is defined,
// an LFSR stalls rsp_tready on roughly 1 cycle in 8.

module axis64_kvs_rsp_monitor #(
    parameter int unsigned TS_DEPTH = 64,
    parameter int unsigned LAT_W    = 32,
    parameter int unsigned CNT_W    = 32,
    parameter logic [15:0] BP_SEED  = 16'hACE1
) (
    input  logic                        to_net_clk_390,
    input  logic                        to_net_clk_390_rst_n,
    input  logic                        enable,
    input  logic                        clear,
    input  logic                        req_tvalid,
    input  logic                        req_tready,
    input  logic                        req_tlast,
    input  logic [63:0]                 rsp_tdata,
    input  logic [7:0]                  rsp_tkeep,
    input  logic                        rsp_tlast,
    input  logic                        rsp_tvalid,
    output logic                        rsp_tready,
    output logic [CNT_W-1:0]            nr_req,
    output logic [CNT_W-1:0]            nr_rsp,
    output logic [47:0]                 nr_bytes,
    output logic [$clog2(TS_DEPTH):0]   outstanding,
    output logic [LAT_W-1:0]            last_latency,
    output logic [LAT_W-1:0]            min_latency,
    output logic [LAT_W-1:0]            max_latency,
    output logic                        err_overflow,
    output logic                        err_unexpected,
    output logic                        in_packet
);

    localparam int unsigned PTR_W = $clog2(TS_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_MAX  = '1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(TS_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_e;

    // Number of bytes enabled in one 64-bit beat.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    state_e              state_q, state_d;
    logic [LAT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]    nr_req_q, nr_req_d;
    logic [CNT_W-1:0]    nr_rsp_q, nr_rsp_d;
    logic [47:0]         nr_bytes_q, nr_bytes_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic [LAT_W-1:0]    last_latency_q, last_latency_d;
    logic [LAT_W-1:0]    min_latency_q, min_latency_d;
    logic [LAT_W-1:0]    max_latency_q, max_latency_d;
    logic                err_overflow_q, err_overflow_d;
    logic                err_unexpected_q, err_unexpected_d;
    logic [LAT_W-1:0]    mem_q [TS_DEPTH];

    logic                rsp_tready_s;
    logic                beat_s;
    logic                eop_s;
    logic                req_fire_s;
    logic                empty_s;
    logic                full_s;
    logic                push_s;
    logic                pop_s;
    logic [LAT_W-1:0]    lat_s;
    logic                unused_s;

    // The payload is never inspected; only the handshake matters.
    assign unused_s = ^{rsp_tdata, BP_SEED};

`ifdef AXIS_MON_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR with taps 16,14,13,11, stepped every cycle.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // LFSR state register; it restarts from the seed on reset.
    always_ff @(posedge to_net_clk_390 or negedge to_net_clk_390_rst_n) begin
        if (!to_net_clk_390_rst_n) begin
            lfsr_q <= BP_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rsp_tready_s = enable & to_net_clk_390_rst_n & (lfsr_q[2:0] != 3'd0);
`else
    // Ready is held low while reset is asserted, even if enable is high.
    assign rsp_tready_s = enable & to_net_clk_390_rst_n;
`endif

    assign beat_s     = rsp_tvalid & rsp_tready_s;
    assign eop_s      = beat_s & rsp_tlast;
    assign req_fire_s = req_tvalid & req_tready & req_tlast & enable;
    assign empty_s    = (occ_q == {OCC_W{1'b0}});
    assign full_s     = (occ_q == OCC_FULL);
    // Empty and full are judged on the occupancy before this cycle.
    // When a pop frees the head slot, a push into a full FIFO still succeeds.
    assign pop_s      = eop_s & ~empty_s & ~clear;
    assign push_s     = req_fire_s & (~full_s | pop_s) & ~clear;
    assign lat_s      = cycle_cnt_q - mem_q[rd_ptr_q];

    // Next-state logic for the statistics, the FIFO pointers and the packet FSM.
    always_comb begin
        cycle_cnt_d      = cycle_cnt_q + LAT_ONE;
        state_d          = state_q;
        nr_req_d         = nr_req_q;
        nr_rsp_d         = nr_rsp_q;
        nr_bytes_d       = nr_bytes_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        occ_d            = occ_q;
        last_latency_d   = last_latency_q;
        min_latency_d    = min_latency_q;
        max_latency_d    = max_latency_q;
        err_overflow_d   = err_overflow_q;
        err_unexpected_d = err_unexpected_q;
        if (clear) begin
            state_d          = ST_IDLE;
            nr_req_d         = {CNT_W{1'b0}};
            nr_rsp_d         = {CNT_W{1'b0}};
            nr_bytes_d       = 48'd0;
            wr_ptr_d         = {PTR_W{1'b0}};
            rd_ptr_d         = {PTR_W{1'b0}};
            occ_d            = {OCC_W{1'b0}};
            last_latency_d   = {LAT_W{1'b0}};
            min_latency_d    = LAT_MAX;
            max_latency_d    = {LAT_W{1'b0}};
            err_overflow_d   = 1'b0;
            err_unexpected_d = 1'b0;
        end else begin
            nr_req_d = (req_fire_s && (nr_req_q != CNT_MAX)) ? nr_req_q + CNT_ONE : nr_req_q;
            nr_rsp_d = (eop_s && (nr_rsp_q != CNT_MAX)) ? nr_rsp_q + CNT_ONE : nr_rsp_q;
            nr_bytes_d = beat_s ? nr_bytes_q + {44'd0, popcount8(rsp_tkeep)} : nr_bytes_q;
            err_overflow_d   = err_overflow_q | (req_fire_s & ~push_s);
            err_unexpected_d = err_unexpected_q | (eop_s & empty_s);
            wr_ptr_d = push_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
            rd_ptr_d = pop_s ? rd_ptr_q + PTR_ONE : rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   occ_d = occ_q + OCC_ONE;
                2'b01:   occ_d = occ_q - OCC_ONE;
                default: occ_d = occ_q;
            endcase
            last_latency_d = pop_s ? lat_s : last_latency_q;
            min_latency_d  = (pop_s && (lat_s < min_latency_q)) ? lat_s : min_latency_q;
            max_latency_d  = (pop_s && (lat_s > max_latency_q)) ? lat_s : max_latency_q;
            case (state_q)
                ST_IDLE: state_d = (beat_s && !rsp_tlast) ? ST_BODY : ST_IDLE;
                ST_BODY: state_d = eop_s ? ST_IDLE : ST_BODY;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers; the reset values match the values that clear produces,
    // except that cycle_cnt also restarts from zero.
    always_ff @(posedge to_net_clk_390 or negedge to_net_clk_390_rst_n) begin
        if (!to_net_clk_390_rst_n) begin
            state_q          <= ST_IDLE;
            cycle_cnt_q      <= {LAT_W{1'b0}};
            nr_req_q         <= {CNT_W{1'b0}};
            nr_rsp_q         <= {CNT_W{1'b0}};
            nr_bytes_q       <= 48'd0;
            wr_ptr_q         <= {PTR_W{1'b0}};
            rd_ptr_q         <= {PTR_W{1'b0}};
            occ_q            <= {OCC_W{1'b0}};
            last_latency_q   <= {LAT_W{1'b0}};
            min_latency_q    <= LAT_MAX;
            max_latency_q    <= {LAT_W{1'b0}};
            err_overflow_q   <= 1'b0;
            err_unexpected_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cycle_cnt_q      <= cycle_cnt_d;
            nr_req_q         <= nr_req_d;
            nr_rsp_q         <= nr_rsp_d;
            nr_bytes_q       <= nr_bytes_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            occ_q            <= occ_d;
            last_latency_q   <= last_latency_d;
            min_latency_q    <= min_latency_d;
            max_latency_q    <= max_latency_d;
            err_overflow_q   <= err_overflow_d;
            err_unexpected_q <= err_unexpected_d;
        end
    end

    // Timestamp storage. The pointers track validity, so the memory needs no reset.
    always_ff @(posedge to_net_clk_390) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= cycle_cnt_q;
        end
    end

    assign rsp_tready     = rsp_tready_s;
    assign nr_req         = nr_req_q;
    assign nr_rsp         = nr_rsp_q;
    assign nr_bytes       = nr_bytes_q;
    assign outstanding    = occ_q;
    assign last_latency   = last_latency_q;
    assign min_latency    = min_latency_q;
    assign max_latency    = max_latency_q;
    assign err_overflow   = err_overflow_q;
    assign err_unexpected = err_unexpected_q;
    assign in_packet      = (state_q == ST_BODY);

endmodule

// File: tb/tb_axis64_kvs_rsp_monitor.sv
// Testbench for axis64_kvs_rsp_monitor (default build, no backpressure).
// A transaction-level model (timestamp queue, plain counters) predicts every output.

module tb_axis64_kvs_rsp_monitor;

    localparam int TS_DEPTH = 4;
    localparam int LAT_W    = 8;
    localparam int CNT_W    = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, clear;
    logic        req_tvalid, req_tready, req_tlast;
    logic [63:0] rsp_tdata;
    logic [7:0]  rsp_tkeep;
    logic        rsp_tlast, rsp_tvalid;
    logic        rsp_tready;
    logic [CNT_W-1:0] nr_req, nr_rsp;
    logic [47:0] nr_bytes;
    logic [2:0]  outstanding;
    logic [LAT_W-1:0] last_latency, min_latency, max_latency;
    logic        err_overflow, err_unexpected, in_packet;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          m_cyc;
    longint      m_req, m_rsp, m_bytes;
    int          m_q[$];
    int          m_last, m_min, m_max;
    bit          m_ovf, m_unx, m_inpkt;
    int          t_first;

    always #5 clk = ~clk;

    axis64_kvs_rsp_monitor #(
        .TS_DEPTH(TS_DEPTH), .LAT_W(LAT_W), .CNT_W(CNT_W), .BP_SEED(16'hACE1)
    ) dut (
        .to_net_clk_390(clk), .to_net_clk_390_rst_n(rst_n),
        .enable(enable), .clear(clear),
        .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tlast(req_tlast),
        .rsp_tdata(rsp_tdata), .rsp_tkeep(rsp_tkeep), .rsp_tlast(rsp_tlast),
        .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready),
        .nr_req(nr_req), .nr_rsp(nr_rsp), .nr_bytes(nr_bytes),
        .outstanding(outstanding), .last_latency(last_latency),
        .min_latency(min_latency), .max_latency(max_latency),
        .err_overflow(err_overflow), .err_unexpected(err_unexpected),
        .in_packet(in_packet)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0; m_req = 0; m_rsp = 0; m_bytes = 0;
        m_q.delete();
        m_last = 0; m_min = 255; m_max = 0;
        m_ovf = 1'b0; m_unx = 1'b0; m_inpkt = 1'b0;
    endtask

    task automatic model_clear();
        m_req = 0; m_rsp = 0; m_bytes = 0;
        m_q.delete();
        m_last = 0; m_min = 255; m_max = 0;
        m_ovf = 1'b0; m_unx = 1'b0; m_inpkt = 1'b0;
    endtask

    // One clock: apply the model to the inputs seen at the edge, then return at the negedge.
    task automatic tick();
        bit beat, eop, fire;
        int pre, lat, ts;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            beat = rsp_tvalid & enable;
            eop  = beat & rsp_tlast;
            fire = req_tvalid & req_tready & req_tlast & enable;
            if (clear) begin
                model_clear();
            end else begin
                pre = m_q.size();
                if (fire && m_req != 64'h0000_0000_FFFF_FFFF) m_req++;
                if (eop && m_rsp != 64'h0000_0000_FFFF_FFFF) m_rsp++;
                if (beat) m_bytes = (m_bytes + longint'($countones(rsp_tkeep))) & 64'h0000_FFFF_FFFF_FFFF;
                if (eop) begin
                    if (pre == 0) begin
                        m_unx = 1'b1;
                    end else begin
                        ts = m_q.pop_front();
                        lat = (m_cyc - ts) & 255;
                        m_last = lat;
                        if (lat < m_min) m_min = lat;
                        if (lat > m_max) m_max = lat;
                    end
                end
                if (fire) begin
                    if (pre < TS_DEPTH || (eop && pre > 0)) m_q.push_back(m_cyc);
                    else m_ovf = 1'b1;
                end
                if (beat) m_inpkt = !rsp_tlast;
            end
            m_cyc = (m_cyc + 1) % 256;
        end
        @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".nr_req"}, 64'(nr_req), 64'(m_req));
        chk({tag, ".nr_rsp"}, 64'(nr_rsp), 64'(m_rsp));
        chk({tag, ".nr_bytes"}, 64'(nr_bytes), 64'(m_bytes));
        chk({tag, ".outstanding"}, 64'(outstanding), 64'(m_q.size()));
        chk({tag, ".last_lat"}, 64'(last_latency), 64'(m_last));
        chk({tag, ".min_lat"}, 64'(min_latency), 64'(m_min));
        chk({tag, ".max_lat"}, 64'(max_latency), 64'(m_max));
        chk({tag, ".ovf"}, 64'(err_overflow), 64'(m_ovf));
        chk({tag, ".unx"}, 64'(err_unexpected), 64'(m_unx));
        chk({tag, ".in_pkt"}, 64'(in_packet), 64'(m_inpkt));
        chk({tag, ".tready"}, 64'(rsp_tready), 64'(enable & rst_n));
    endtask

    task automatic idle_until(input int target);
        int n;
        n = 0;
        while (m_cyc != target && n < 300) begin
            tick();
            n++;
        end
        if (m_cyc != target) chk("wait_cyc", 64'(m_cyc), 64'(target));
    endtask

    task automatic send_req();
        req_tvalid = 1'b1; req_tready = 1'b1; req_tlast = 1'b1;
        tick();
        req_tvalid = 1'b0; req_tready = 1'b0; req_tlast = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] keep, input logic last);
        rsp_tvalid = 1'b1; rsp_tkeep = keep; rsp_tlast = last;
        rsp_tdata = {$urandom, $urandom};
        tick();
        rsp_tvalid = 1'b0; rsp_tlast = 1'b0; rsp_tkeep = 8'h00;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        int base;
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0;
        req_tvalid = 1'b0; req_tready = 1'b0; req_tlast = 1'b0;
        rsp_tdata = 64'd0; rsp_tkeep = 8'h00; rsp_tlast = 1'b0; rsp_tvalid = 1'b0;
        model_reset();
        tick(); tick();
        // reset values
        check_all("reset");
        chk("reset.min_ones", 64'(min_latency), 64'd255);
        rst_n = 1'b1;
        enable = 1'b1;

        // basic latency: request at 100, 3-beat response ending at 140
        idle_until(100);
        send_req();
        idle_until(138);
        send_beat(8'hFF, 1'b0);
        chk("tp1.in_pkt", 64'(in_packet), 64'd1);
        send_beat(8'hFF, 1'b0);
        send_beat(8'h0F, 1'b1);
        chk("tp1.lat", 64'(last_latency), 64'd40);
        chk("tp1.nr_req", 64'(nr_req), 64'd1);
        chk("tp1.nr_rsp", 64'(nr_rsp), 64'd1);
        chk("tp1.bytes", 64'(nr_bytes), 64'd20);
        chk("tp1.outst", 64'(outstanding), 64'd0);
        check_all("tp1");

        // four requests, responses at +10..+40
        pulse_clear();
        base = m_cyc;
        for (int i = 0; i < 4; i++) send_req();
        for (int i = 0; i < 4; i++) begin
            idle_until((base + i + 10 * (i + 1)) % 256);
            send_beat(8'h01, 1'b1);
        end
        chk("tp2.min", 64'(min_latency), 64'd10);
        chk("tp2.max", 64'(max_latency), 64'd40);
        chk("tp2.last", 64'(last_latency), 64'd40);
        check_all("tp2");

        // overflow with depth 4
        pulse_clear();
        t_first = m_cyc;
        for (int i = 0; i < 5; i++) send_req();
        chk("tp3.ovf", 64'(err_overflow), 64'd1);
        chk("tp3.outst", 64'(outstanding), 64'd4);
        chk("tp3.nr_req", 64'(nr_req), 64'd5);
        tick(); tick();
        base = m_cyc;
        send_beat(8'hFF, 1'b1);
        chk("tp3.first_match", 64'(last_latency), 64'((base - t_first) & 255));
        check_all("tp3");

        // unexpected response, then simultaneous push/pop on empty
        pulse_clear();
        send_beat(8'h03, 1'b1);
        chk("tp4.unx", 64'(err_unexpected), 64'd1);
        chk("tp4.nr_rsp", 64'(nr_rsp), 64'd1);
        chk("tp4.min", 64'(min_latency), 64'd255);
        pulse_clear();
        req_tvalid = 1'b1; req_tready = 1'b1; req_tlast = 1'b1;
        send_beat(8'h01, 1'b1);
        req_tvalid = 1'b0; req_tready = 1'b0; req_tlast = 1'b0;
        chk("tp4.sim_unx", 64'(err_unexpected), 64'd1);
        chk("tp4.sim_outst", 64'(outstanding), 64'd1);
        check_all("tp4");

        // latency across counter wrap
        pulse_clear();
        idle_until(250);
        send_req();
        idle_until(4);
        send_beat(8'h01, 1'b1);
        chk("tp5.wrap", 64'(last_latency), 64'd10);

        // async reset mid-packet
        send_req();
        send_beat(8'hFF, 1'b0);
        chk("tp6.in_pkt", 64'(in_packet), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("tp6.rst_in_pkt", 64'(in_packet), 64'd0);
        chk("tp6.rst_min", 64'(min_latency), 64'd255);
        check_all("tp6.rst");
        tick();
        rst_n = 1'b1;
        send_beat(8'hFF, 1'b0);
        send_beat(8'h01, 1'b1);
        chk("tp6.new_pkt_rsp", 64'(nr_rsp), 64'd1);
        check_all("tp6.after");

        // clear with three outstanding
        for (int i = 0; i < 3; i++) send_req();
        chk("tp7.outst3", 64'(outstanding), 64'd3);
        req_tvalid = 1'b1; req_tready = 1'b1; req_tlast = 1'b1;
        pulse_clear();
        req_tvalid = 1'b0; req_tready = 1'b0; req_tlast = 1'b0;
        chk("tp7.outst0", 64'(outstanding), 64'd0);
        chk("tp7.unx0", 64'(err_unexpected), 64'd0);
        chk("tp7.min", 64'(min_latency), 64'd255);
        check_all("tp7");

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            enable     = ($urandom_range(0, 9) != 0);
            clear      = ($urandom_range(0, 59) == 0);
            req_tvalid = ($urandom_range(0, 2) == 0);
            req_tready = ($urandom_range(0, 3) != 0);
            req_tlast  = ($urandom_range(0, 1) == 0);
            rsp_tvalid = ($urandom_range(0, 1) == 0);
            rsp_tlast  = ($urandom_range(0, 2) == 0);
            rsp_tkeep  = 8'($urandom);
            rsp_tdata  = {$urandom, $urandom};
            tick();
            check_all("rand");
        end
        clear = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis64_kvs_rsp_monitor.md
Name: axis64_kvs_rsp_monitor

Overview:
Synthesizable response-side monitor for the 64-bit AXI-Stream KVS network path. It sinks the to_net response stream and snoops the from_net request handshake to timestamp each request. It reports request/response/byte counts and per-request round-trip latency in to_net clock cycles. It replaces simulation-only bookkeeping for on-board loopback runs; software reads the stat outputs through existing status registers.

Parameters:
TS_DEPTH, 64, timestamp FIFO entries, power of 2, 2..1024
LAT_W, 32, width of the free-running cycle counter and of all latency outputs
CNT_W, 32, width of the request/response counters
BP_SEED, 16'hACE1, LFSR seed, used only with the optional feature; must be nonzero

Ports:
to_net_clk_390  in  1  clock for all logic
to_net_clk_390_rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = accept responses and record requests
clear  in  1  synchronous, one-cycle: zero all statistics, flush FIFO
req_tvalid  in  1  snoop of from_net tvalid
req_tready  in  1  snoop of from_net tready
req_tlast  in  1  snoop of from_net tlast
rsp_tdata  in  64  response data (ignored except for handshake)
rsp_tkeep  in  8  response byte enables
rsp_tlast  in  1  response end of packet
rsp_tvalid  in  1  response valid
rsp_tready  out  1  response ready
nr_req  out  CNT_W  requests seen (req tlast handshakes)
nr_rsp  out  CNT_W  responses completed (rsp tlast handshakes)
nr_bytes  out  48  sum of set tkeep bits over accepted response beats
outstanding  out  clog2(TS_DEPTH)+1  FIFO occupancy
last_latency  out  LAT_W  latency of most recent matched response
min_latency  out  LAT_W  minimum matched latency
max_latency  out  LAT_W  maximum matched latency
err_overflow  out  1  sticky: request seen with FIFO full
err_unexpected  out  1  sticky: response completed with FIFO empty
in_packet  out  1  FSM is in BODY

Behaviour:
- Reset (async assert, sync deassert expected from the source): rsp_tready=0, all counters/latencies/occupancy=0, min_latency=all ones, stickies=0, FSM=IDLE, cycle counter=0.
- cycle_cnt: LAT_W-bit free-running counter, +1 every cycle, wraps; never cleared by clear.
- req_fire = req_tvalid & req_tready & req_tlast & enable. On req_fire: nr_req+1; push cycle_cnt if FIFO not full, else drop it and set err_overflow.
- rsp_tready = enable (see Optional Feature). beat = rsp_tvalid & rsp_tready.
- FSM: IDLE --beat & !rsp_tlast--> BODY; BODY --beat & rsp_tlast--> IDLE; a single-beat packet (beat & rsp_tlast in IDLE) stays in IDLE. in_packet = (state==BODY).
- Every beat: nr_bytes += popcount(rsp_tkeep), with no contiguity check.
- On beat & rsp_tlast: nr_rsp+1. If FIFO non-empty (pre-cycle state): pop head; lat = cycle_cnt - head, modulo 2^LAT_W, so wrap is handled. last_latency=lat; min/max updated with lat. If empty: set err_unexpected; latency outputs unchanged.
- Simultaneous push and pop: emptiness and fullness are judged on pre-cycle occupancy. Full + push + pop means both succeed and occupancy is unchanged. Empty + push + pop means the push is stored and the pop is flagged unexpected.
- All stat outputs are registered and reflect an event on the cycle after its handshake edge (latency 1).
- Counters saturate at all ones. nr_bytes wraps at 2^48.
- clear: next cycle all stats, stickies, FIFO and FSM return to reset values, except cycle_cnt. Events coincident with clear are discarded.
- enable=0: rsp_tready=0 and req_fire is suppressed. The FSM holds its state, so re-enabling mid-packet resumes in BODY.
- Async reset mid-packet: everything returns to reset values immediately. The partial packet's later beats count as a new packet.

Optional Feature:
AXIS_MON_BACKPRESSURE_EN
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with BP_SEED on reset, advances every cycle. rsp_tready = enable & (lfsr[2:0] != 0), giving about a 1/8 stall rate to exercise upstream backpressure.
- Undefined: no LFSR is instantiated and rsp_tready = enable.

Test Plan:
- Request tlast at cycle_cnt=100; 3-beat response with tkeep FF,FF,0F and tlast at cycle_cnt=140 -> last_latency=40, nr_req=1, nr_rsp=1, nr_bytes=20, outstanding=0.
- 4 requests, then responses at +10,+20,+30,+40 cycles after their requests -> min_latency=10, max_latency=40, last_latency=40.
- TS_DEPTH=4, 5 requests with no responses -> err_overflow=1, outstanding=4, nr_req=5. The first response then matches request 1's timestamp.
- Response tlast with empty FIFO -> err_unexpected=1, nr_rsp=1, min_latency stays all ones; simultaneous push/pop on empty -> err_unexpected=1, outstanding=1.
- LAT_W=8: request at cycle_cnt=250, response tlast at cycle_cnt=4 -> last_latency=10.
- Reset asserted mid-packet with in_packet=1 -> all outputs at reset values, in_packet=0. Pulse clear with outstanding=3 -> outstanding=0, stickies=0, min_latency=all ones next cycle.
